// File: rtl/inert_sensor_resp.sv
// inert_sensor_resp
// SPI responder modelling the inertial sensor at the far end of the
// e-bike inertial link. It decodes 16-bit command frames and accepts
// configuration writes. Register reads return a coherent snapshot of the
// roll, yaw, AY and AZ inputs. INT is raised at a configurable data rate.
//
// Ports
//   clk, rst          system clock, async active-high reset
//   SS_n, SCLK, MOSI  SPI from master (async to clk, SCLK idles high)
//   MISO              read data, MSB first, 0 while SS_n high
//   INT               data-ready level interrupt
//   roll_in..az_in    live sensor values captured into the snapshot
//   wr_vld            1-cycle pulse on a committed config write
//   wr_addr, wr_data  address/data of the last committed write
module inert_sensor_resp #(
    parameter int          ODR_CYCLES = 50000,
    parameter logic [7:0]  WHO_AM_I   = 8'h6A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] roll_in,
    input  logic [15:0] yaw_in,
    input  logic [15:0] ay_in,
    input  logic [15:0] az_in,
    output logic        wr_vld,
    output logic [6:0]  wr_addr,
    output logic [7:0]  wr_data
);

    localparam int             CW       = $clog2(ODR_CYCLES);
    localparam logic [CW-1:0]  ODR_LAST = CW'(ODR_CYCLES - 1);

    // ---------------------------------------------------------------
    // Synchronizers and edge detection. SS_n/SCLK flops reset to their
    // idle-high level so reset release does not look like an edge.
    // ---------------------------------------------------------------
    logic [1:0] ss_sync, sclk_sync, mosi_sync;
    logic       ss_q, sclk_q;
    logic       ss_s, sclk_s, mosi_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync   <= 2'b11;
            sclk_sync <= 2'b11;
            mosi_sync <= 2'b00;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b1;
        end else begin
            ss_sync   <= {ss_sync[0], SS_n};
            sclk_sync <= {sclk_sync[0], SCLK};
            mosi_sync <= {mosi_sync[0], MOSI};
            ss_q      <= ss_sync[1];
            sclk_q    <= sclk_sync[1];
        end
    end

    assign ss_s   = ss_sync[1];
    assign sclk_s = sclk_sync[1];
    assign mosi_s = mosi_sync[1];

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    assign ss_fall   = ~ss_s & ss_q;
    assign ss_rise   = ss_s & ~ss_q;
    // SCLK edges only matter inside a frame
    assign sclk_rise = sclk_s & ~sclk_q & ~ss_s;
    assign sclk_fall = ~sclk_s & sclk_q & ~ss_s;

    // ---------------------------------------------------------------
    // Frame shift/transmit datapath
    // ---------------------------------------------------------------
    logic [4:0]  rcnt;
    logic [15:0] rx;
    logic [7:0]  tx;
    logic [15:0] rx_shift;
    logic [7:0]  rd_data;

    logic [7:0]  cfg_0d, cfg_10, cfg_11, cfg_14;
    logic [15:0] snap_roll, snap_yaw, snap_ay, snap_az;

    assign rx_shift = {rx[14:0], mosi_s};

    // Read mux is addressed by the header byte as it completes (rise 8)
    always_comb begin
        rd_data = 8'h00;
        case (rx_shift[6:0])
            7'h0D:   rd_data = cfg_0d;
            7'h0F:   rd_data = WHO_AM_I;
            7'h10:   rd_data = cfg_10;
            7'h11:   rd_data = cfg_11;
            7'h14:   rd_data = cfg_14;
            7'h24:   rd_data = snap_roll[7:0];
            7'h25:   rd_data = snap_roll[15:8];
            7'h26:   rd_data = snap_yaw[7:0];
            7'h27:   rd_data = snap_yaw[15:8];
            7'h2A:   rd_data = snap_ay[7:0];
            7'h2B:   rd_data = snap_ay[15:8];
            7'h2C:   rd_data = snap_az[7:0];
            7'h2D:   rd_data = snap_az[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= 5'd0;
            rx   <= 16'h0000;
            tx   <= 8'h00;
        end else if (ss_fall) begin
            rcnt <= 5'd0;
            rx   <= 16'h0000;
            tx   <= 8'h00;
        end else if (sclk_rise) begin
            rx <= rx_shift;
            if (rcnt != 5'd16)
                rcnt <= rcnt + 5'd1;
            if (rcnt == 5'd7)
                tx <= rx_shift[7] ? rd_data : 8'h00;
        end else if (sclk_fall && rcnt >= 5'd9) begin
            tx <= {tx[6:0], 1'b0};
        end
    end

    // Gate on the raw pin so MISO drops as soon as the master deselects,
    // and on ss_q so stale tx bits never leak before the fall clears tx.
    assign MISO = tx[7] & ~ss_q & ~SS_n;

    // ---------------------------------------------------------------
    // Commit on SS_n rise of a complete frame
    // ---------------------------------------------------------------
    logic commit, wr_hit, int_clr;
    logic [6:0] c_addr;

    assign c_addr  = rx[14:8];
    assign commit  = ss_rise & (rcnt == 5'd16);
    assign wr_hit  = commit & ~rx[15] &
                     ((c_addr == 7'h0D) | (c_addr == 7'h10) |
                      (c_addr == 7'h11) | (c_addr == 7'h14));
    assign int_clr = commit & rx[15] & (c_addr == 7'h2D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_vld  <= 1'b0;
            wr_addr <= 7'h00;
            wr_data <= 8'h00;
            cfg_0d  <= 8'h00;
            cfg_10  <= 8'h00;
            cfg_11  <= 8'h00;
            cfg_14  <= 8'h00;
        end else begin
            wr_vld <= wr_hit;
            if (wr_hit) begin
                wr_addr <= c_addr;
                wr_data <= rx[7:0];
                case (c_addr)
                    7'h0D:   cfg_0d <= rx[7:0];
                    7'h10:   cfg_10 <= rx[7:0];
                    7'h11:   cfg_11 <= rx[7:0];
                    default: cfg_14 <= rx[7:0];
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Output data rate, snapshot and INT
    // ---------------------------------------------------------------
    logic          int_en, tick, pend, apply;
    logic [CW-1:0] odr_cnt;

    assign int_en = cfg_0d[1];
    assign tick   = int_en & (odr_cnt == ODR_LAST);
    // Requiring ss_q high too pushes a deferred tick to the cycle after the
    // commit, so the frame that just ended keeps its own snapshot.
    assign apply  = (tick | pend) & ss_s & ss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odr_cnt   <= '0;
            pend      <= 1'b0;
            INT       <= 1'b0;
            snap_roll <= 16'h0000;
            snap_yaw  <= 16'h0000;
            snap_ay   <= 16'h0000;
            snap_az   <= 16'h0000;
        end else if (!int_en) begin
            odr_cnt <= '0;
            pend    <= 1'b0;
            INT     <= 1'b0;
        end else begin
            odr_cnt <= tick ? '0 : odr_cnt + CW'(1);
            if (apply) begin
                // set wins over a same-cycle 0x2D clear
                snap_roll <= roll_in;
                snap_yaw  <= yaw_in;
                snap_ay   <= ay_in;
                snap_az   <= az_in;
                pend      <= 1'b0;
                INT       <= 1'b1;
            end else begin
                if (tick)
                    pend <= 1'b1;
                if (int_clr)
                    INT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inert_sensor_resp.sv
// Bench for inert_sensor_resp: a directed frame table, hand-written INT /
// coherency / reset sequences, and a randomized phase checked against a
// register-map model of the sensor.
module tb_inert_sensor_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO, INT, wr_vld;
    logic [15:0] roll_in = 16'h0, yaw_in = 16'h0, ay_in = 16'h0, az_in = 16'h0;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;

    inert_sensor_resp #(.ODR_CYCLES(100), .WHO_AM_I(8'h6A)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .INT(INT),
        .roll_in(roll_in), .yaw_in(yaw_in), .ay_in(ay_in), .az_in(az_in),
        .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "timeout");
    end

    // event monitor
    int cyc = 0, wr_cnt = 0, wr_cyc = 0, int_rises = 0, int_rise_cyc = 0;
    logic int_prev = 1'b0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_vld) begin
            wr_cnt = wr_cnt + 1;
            wr_cyc = cyc;
        end
        if (INT && !int_prev) begin
            int_rises    = int_rises + 1;
            int_rise_cyc = cyc;
        end
        int_prev = INT;
    end

    int ncmp = 0, nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI master: 8 clk half period, data changes on SCLK fall, MISO
    // sampled just before the SCLK rise.
    task automatic spi_start();
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        SCLK = 1'b0;
        MOSI = b;
        repeat (8) @(negedge clk);
        m = MISO;
        SCLK = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_end(input int gap);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic xfer(input logic [15:0] f, input int nb, input int gap, output logic [15:0] m);
        logic b;
        m = 16'h0000;
        spi_start();
        for (int i = 0; i < nb; i++) begin
            spi_bit(f[15-i], b);
            m[15-i] = b;
        end
        spi_end(gap);
    endtask

    // sensor register-map model
    logic [7:0]  mcfg [0:127];
    logic [15:0] ms_roll, ms_yaw, ms_ay, ms_az;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (a == 7'h0F) v = 8'h6A;
        else if (a == 7'h0D || a == 7'h10 || a == 7'h11 || a == 7'h14) v = mcfg[a];
        else if (a == 7'h24) v = ms_roll[7:0];
        else if (a == 7'h25) v = ms_roll[15:8];
        else if (a == 7'h26) v = ms_yaw[7:0];
        else if (a == 7'h27) v = ms_yaw[15:8];
        else if (a == 7'h2A) v = ms_ay[7:0];
        else if (a == 7'h2B) v = ms_ay[15:8];
        else if (a == 7'h2C) v = ms_az[7:0];
        else if (a == 7'h2D) v = ms_az[15:8];
        return v;
    endfunction

    function automatic logic writable(input logic [6:0] a);
        return (a == 7'h0D || a == 7'h10 || a == 7'h11 || a == 7'h14);
    endfunction

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic        chk_miso;
        logic [15:0] miso;
        logic        wr;
        logic [6:0]  addr;
        logic [7:0]  data;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [15:0] rw;
        logic        b;
        int          w0, r0, k;

        tbl[0]  = '{16'h0D02, 16, 1'b1, 16'h0000, 1'b1, 7'h0D, 8'h02};
        tbl[1]  = '{16'h1053, 16, 1'b1, 16'h0000, 1'b1, 7'h10, 8'h53};
        tbl[2]  = '{16'h8D00, 16, 1'b1, 16'h0002, 1'b0, 7'h10, 8'h53};
        tbl[3]  = '{16'h8F00, 16, 1'b1, 16'h006A, 1'b0, 7'h10, 8'h53};
        tbl[4]  = '{16'h9000, 16, 1'b1, 16'h0053, 1'b0, 7'h10, 8'h53};
        tbl[5]  = '{16'h8E00, 16, 1'b1, 16'h0000, 1'b0, 7'h10, 8'h53};
        tbl[6]  = '{16'h2077, 16, 1'b1, 16'h0000, 1'b0, 7'h10, 8'h53};
        tbl[7]  = '{16'h1477, 10, 1'b0, 16'h0000, 1'b0, 7'h10, 8'h53};
        tbl[8]  = '{16'h9400, 16, 1'b1, 16'h0000, 1'b0, 7'h10, 8'h53};
        tbl[9]  = '{16'h1411, 16, 1'b1, 16'h0000, 1'b1, 7'h14, 8'h11};
        tbl[10] = '{16'h9400, 16, 1'b1, 16'h0011, 1'b0, 7'h14, 8'h11};
        tbl[11] = '{16'h11FF, 16, 1'b1, 16'h0000, 1'b1, 7'h11, 8'hFF};
        tbl[12] = '{16'h91AB, 16, 1'b1, 16'h00FF, 1'b0, 7'h11, 8'hFF};
        tbl[13] = '{16'h0D00, 16, 1'b1, 16'h0000, 1'b1, 7'h0D, 8'h00};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(MISO), 32'(1'b0));
        chk("rst_int", 32'(INT), 32'(1'b0));
        chk("rst_wr_vld", 32'(wr_vld), 32'(1'b0));
        chk("rst_wr_addr", 32'(wr_addr), 32'(7'h00));
        chk("rst_wr_data", 32'(wr_data), 32'(8'h00));
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // directed frame table
        for (int t = 0; t < 14; t++) begin
            w0 = wr_cnt;
            xfer(tbl[t].frame, tbl[t].nbits, 10, rw);
            if (tbl[t].chk_miso)
                chk($sformatf("tbl%0d_miso", t), 32'(rw), 32'(tbl[t].miso));
            chk($sformatf("tbl%0d_wr_pulses", t), 32'(wr_cnt - w0), 32'(tbl[t].wr));
            chk($sformatf("tbl%0d_wr_addr", t), 32'(wr_addr), 32'(tbl[t].addr));
            chk($sformatf("tbl%0d_wr_data", t), 32'(wr_data), 32'(tbl[t].data));
        end

        // INT rate and snapshot reads
        roll_in = 16'h1234; yaw_in = 16'h5678; ay_in = 16'h9ABC; az_in = 16'hBEEF;
        chk("int_idle", 32'(INT), 32'(1'b0));
        r0 = int_rises;
        xfer(16'h0D02, 16, 2, rw);
        k = 0;
        while (int_rises == r0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("int_rise_seen", 32'(int_rises != r0), 32'(1'b1));
        chk("int_rise_delay", 32'(int_rise_cyc - wr_cyc), 32'd100);
        xfer(16'hA400, 16, 10, rw); chk("rd_roll_l", 32'(rw), 32'h0034);
        xfer(16'hA500, 16, 10, rw); chk("rd_roll_h", 32'(rw), 32'h0012);
        xfer(16'hAC00, 16, 10, rw); chk("rd_az_l", 32'(rw), 32'h00EF);
        xfer(16'hAD00, 16, 0, rw);  chk("rd_az_h", 32'(rw), 32'h00BE);
        @(negedge clk); @(negedge clk);
        chk("int_before_clear", 32'(INT), 32'(1'b1));
        @(negedge clk);
        chk("int_cleared", 32'(INT), 32'(1'b0));
        repeat (10) @(negedge clk);

        // tick during a frame: frame keeps old data, snapshot follows after
        spi_start();
        rw = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) az_in = 16'h1111;
            spi_bit(rw[15-i] | (16'hAC00 >> (15-i)) & 16'h1, b);
            rw[15-i] = b;
        end
        spi_end(10);
        chk("midburst_old_az", 32'(rw), 32'h00EF);
        chk("midburst_int_set", 32'(INT), 32'(1'b1));
        xfer(16'hAC00, 16, 10, rw); chk("after_az_l", 32'(rw), 32'h0011);
        xfer(16'hAD00, 16, 10, rw); chk("after_az_h", 32'(rw), 32'h0011);

        // reset in the middle of a read of 0x11 (0xFF)
        repeat (120) @(negedge clk);
        chk("int_pre_rst", 32'(INT), 32'(1'b1));
        spi_start();
        for (int i = 0; i < 9; i++) spi_bit((16'h9100 >> (15-i)) & 16'h1, b);
        chk("miso_mid_read", 32'(MISO), 32'(1'b1));
        rst = 1'b1;
        #1;
        chk("rst_mid_miso", 32'(MISO), 32'(1'b0));
        chk("rst_mid_int", 32'(INT), 32'(1'b0));
        @(negedge clk);
        SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_wr_addr", 32'(wr_addr), 32'(7'h00));
        chk("post_rst_wr_data", 32'(wr_data), 32'(8'h00));
        xfer(16'h8F00, 16, 10, rw); chk("post_rst_who", 32'(rw), 32'h006A);
        xfer(16'h9100, 16, 10, rw); chk("post_rst_cfg11", 32'(rw), 32'h0000);

        // randomized phase against the register-map model
        for (int a = 0; a < 128; a++) mcfg[a] = 8'h00;
        m_addr = 7'h00; m_data = 8'h00;
        roll_in = 16'($urandom); yaw_in = 16'($urandom);
        ay_in = 16'($urandom); az_in = 16'($urandom);
        xfer(16'h0D02, 16, 10, rw);
        repeat (150) @(negedge clk);
        xfer(16'h0D00, 16, 10, rw);
        chk("rand_int_off", 32'(INT), 32'(1'b0));
        ms_roll = roll_in; ms_yaw = yaw_in; ms_ay = ay_in; ms_az = az_in;
        m_addr = 7'h0D; m_data = 8'h00;
        roll_in = 16'($urandom); yaw_in = 16'($urandom);
        ay_in = 16'($urandom); az_in = 16'($urandom);

        for (int n = 0; n < 40; n++) begin
            logic [6:0]  ad;
            logic [7:0]  d;
            logic        rd;
            int          nb, sel, exp_p;
            sel = $urandom_range(0, 14);
            case (sel)
                0: ad = 7'h0D;  1: ad = 7'h0F;  2: ad = 7'h10;  3: ad = 7'h11;
                4: ad = 7'h14;  5: ad = 7'h24;  6: ad = 7'h25;  7: ad = 7'h26;
                8: ad = 7'h27;  9: ad = 7'h2A; 10: ad = 7'h2B; 11: ad = 7'h2C;
               12: ad = 7'h2D; default: ad = 7'($urandom);
            endcase
            rd = 1'($urandom);
            d  = 8'($urandom);
            if (ad == 7'h0D) d[1] = 1'b0;
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16;
            w0 = wr_cnt;
            exp_p = 0;
            xfer({rd, ad, d}, nb, 10, rw);
            if (nb == 16) begin
                if (rd) begin
                    chk($sformatf("rand%0d_rd_%0h", n, ad), 32'(rw), 32'({8'h00, model_rd(ad)}));
                end else begin
                    chk($sformatf("rand%0d_wr_miso", n), 32'(rw), 32'h0);
                    if (writable(ad)) begin
                        mcfg[ad] = d;
                        m_addr = ad;
                        m_data = d;
                        exp_p = 1;
                    end
                end
            end
            chk($sformatf("rand%0d_pulses", n), 32'(wr_cnt - w0), 32'(exp_p));
            chk($sformatf("rand%0d_wr_addr", n), 32'(wr_addr), 32'(m_addr));
            chk($sformatf("rand%0d_wr_data", n), 32'(wr_data), 32'(m_data));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/inert_sensor_resp.md
# inert_sensor_resp

SPI responder that models the inertial sensor at the far end of the e-bike's inertial link. It decodes 16-bit command frames from the SPI master on SS_n/SCLK/MOSI and accepts configuration writes. It answers register reads on MISO with a coherent snapshot of roll rate, yaw rate, AY and AZ, and raises INT at a configurable output data rate. It is used as the sensor model in full-chip simulation and as a drop-in target for the inertial interface bench.

## Interface
- ODR_CYCLES, 50000: clk cycles between data-ready events while INT is enabled (≥64).
- WHO_AM_I, 8'h6A: value returned on reads of address 0x0F.

- clk  in  1  system clock; ≥8× SCLK frequency.
- rst  in  1  reset; asynchronous, active-high.
- SS_n  in  1  active-low slave select from master (asynchronous to clk).
- SCLK  in  1  serial clock; idles high (asynchronous to clk).
- MOSI  in  1  master-out data, MSB first.
- MISO  out  1  responder data, MSB first; 0 whenever SS_n high.
- INT  out  1  data-ready interrupt, active-high, level.
- roll_in, yaw_in, ay_in, az_in  in  16 each  live sensor values, sampled into the snapshot.
- wr_vld  out  1  one-cycle pulse when a write frame commits to a writable register.
- wr_addr  out  7  address of the committed write; holds until the next commit.
- wr_data  out  8  data of the committed write; holds until the next commit.

## Operation
- SS_n, SCLK and MOSI each pass through a 2-flop synchronizer on clk. Edge detects run on the synchronized signals: SCLK rise/fall and SS_n rise/fall.
- Frame format: bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = write data (don't care on reads).
- SS_n fall clears the 5-bit rise counter rcnt, the 16-bit rx shift register and the 8-bit tx register.
- Each SCLK rise shifts MOSI into rx[0] and increments rcnt, saturating at 16.
- MISO = tx[7] while SS_n is low.
- At the rise that sets rcnt = 8:
  - read frame: tx loads read data for address rx[6:0];
  - write frame: tx stays 0.
- A SCLK fall with rcnt ≥ 9 shifts tx left by one, filling with 0. Falls with rcnt ≤ 8 do not shift.
- Read map:
  - 0x0D, 0x10, 0x11, 0x14: config registers.
  - 0x0F: WHO_AM_I.
  - 0x24/0x25: roll L/H.
  - 0x26/0x27: yaw L/H.
  - 0x2A/0x2B: AY L/H.
  - 0x2C/0x2D: AZ L/H.
  - All other addresses return 0x00.
- Frame commit happens on SS_n rise only if rcnt == 16. Otherwise the frame is discarded: no write, no INT clear.
- Write commit: if the address is 0x0D, 0x10, 0x11 or 0x14, the config register updates and wr_vld pulses with wr_addr/wr_data. Other addresses are ignored with no pulse.
- Read commit of 0x2D clears INT.
- INT enable = config reg 0x0D bit1.
  - While enabled, a free-running ODR counter counts 0..ODR_CYCLES-1 and wraps; a data-ready tick is produced at the wrap.
  - While disabled, the counter is held at 0 and INT is cleared.
- On a data-ready tick, if SS_n (synchronized) is high, the snapshot loads all four inputs and INT sets.
  - If SS_n is low, the tick is held pending and applied on the first cycle after SS_n rise, after that frame's commit. This keeps a frame's data coherent.
- If an INT clear (0x2D commit) and a tick apply in the same cycle, INT ends set and the snapshot is updated.
- Reset values:
  - MISO, INT, wr_vld: 0.
  - wr_addr, wr_data, config registers, snapshot, counters, pending flag: 0.

## Timing
- Input-to-decision latency is 3 clk: 2 synchronizer stages plus the edge-detect register.
- The commit (wr_vld, INT clear) is registered 1 clk after the detected SS_n rise.
- MISO changes 1 clk after a detected SCLK fall, or after the rcnt = 8 rise for the first read bit. This meets the master's next SCLK rise when SCLK ≥ 8 clk/period.
- INT rises 1 clk after a tick applies. Tick spacing is exactly ODR_CYCLES clk when no deferral occurs.
- rst asserted mid-frame returns all state to reset immediately. The in-progress frame is lost; the next SS_n fall starts cleanly.

## Test plan
- Write 0x0D02 then 0x1053 (SCLK = clk/16): wr_vld pulses twice with (0x0D, 0x02) and (0x10, 0x53); read 0x8Dxx returns 0x02 in MISO bits 7:0.
- Read 0x8Fxx → MISO second byte 0x6A, first byte 0x00.
- ODR_CYCLES = 100, enable INT, roll_in = 0x1234, az_in = 0xBEEF:
  - INT rises 100 clk after enable;
  - reads of 0xA4, 0xA5, 0xAC, 0xAD return 0x34, 0x12, 0xEF, 0xBE;
  - INT clears 1 clk after the 0xAD frame's SS_n rise.
- Change az_in mid-burst and let a tick fall while SS_n is low: the in-flight frame returns the old value; the snapshot updates after SS_n rise; INT remains set.
- Abort a write after 10 SCLK rises (SS_n rises early): no wr_vld, config unchanged; the next full frame decodes correctly.
- Assert rst mid-read: MISO = 0 and INT = 0 immediately; a subsequent read of 0x8Fxx returns 0x6A.
